// File: rtl/bcd_seq_adder_ctrl.sv
// rtl/bcd_seq_adder_ctrl.sv - multi-digit packed-BCD adder, one digit per cycle through a shared add stage
module bcd_seq_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  work_q, work_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          in_bad;
    logic [3:0]    a_dig;
    logic [3:0]    b_dig;
    logic [4:0]    dig_t;
    logic [3:0]    dig_out;
    logic          dig_carry;

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end
    end

    // Shared single-digit stage; invalid nibbles go through the same decimal correction.
    always_comb begin
        a_dig     = a_q[{idx_q, 2'b00} +: 4];
        b_dig     = b_q[{idx_q, 2'b00} +: 4];
        dig_t     = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
        dig_carry = (dig_t > 5'd9);
        dig_out   = dig_carry ? (dig_t[3:0] - 4'd10) : dig_t[3:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    work_d  = '0;
                    err_d   = in_bad;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                work_d[{idx_q, 2'b00} +: 4] = dig_out;
                carry_d = dig_carry;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    sum_d   = work_d;
                    cout_d  = dig_carry;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_seq_adder_ctrl.sv
// tb/tb_bcd_seq_adder_ctrl.sv - scoreboard bench for bcd_seq_adder_ctrl (DIGITS=4 and DIGITS=1)
module tb_bcd_seq_adder_ctrl;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, cin;
    logic [4*D-1:0] a, b;
    logic          busy, done, cout, err;
    logic [4*D-1:0] sum;

    logic          start1, cin1;
    logic [3:0]    a1, b1;
    logic          busy1, done1, cout1, err1;
    logic [3:0]    sum1;

    typedef struct packed {
        logic [4*D-1:0] sum;
        logic           cout;
        logic           err;
    } exp_t;

    exp_t           sb[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    logic [4*D-1:0] hold_sum = '0;
    logic           hold_cout = 1'b0;

    always #5 clk = ~clk;

    bcd_seq_adder_ctrl #(.DIGITS(D)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    bcd_seq_adder_ctrl #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [4*D-1:0] x, input logic [4*D-1:0] y, input logic c);
        exp_t       r;
        logic [3:0] xd, yd;
        logic [4:0] t;
        r = '0;
        for (int i = 0; i < D; i++) begin
            xd = x[4*i +: 4];
            yd = y[4*i +: 4];
            if (xd > 4'd9 || yd > 4'd9) r.err = 1'b1;
            t = 5'(xd) + 5'(yd) + 5'(c);
            if (t > 5'd9) begin
                r.sum[4*i +: 4] = 4'(t - 5'd10);
                c = 1'b1;
            end else begin
                r.sum[4*i +: 4] = t[3:0];
                c = 1'b0;
            end
        end
        r.cout = c;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            hold_sum  = '0;
            hold_cout = 1'b0;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", sum, e.sum);
                chk("cout", cout, e.cout);
                chk("err", err, e.err);
                hold_sum  = e.sum;
                hold_cout = e.cout;
            end
        end else if (busy) begin
            chk("sum_stable", sum, hold_sum);
            chk("cout_stable", cout, hold_cout);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || done) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", busy | done, 1'b0);
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic run_op(input logic [4*D-1:0] x, input logic [4*D-1:0] y, input logic c);
        int n;
        wait_idle();
        a = x; b = y; cin = c; start = 1'b1;
        sb.push_back(model(x, y, c));
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_accept", busy, 1'b1);
        wait_done("done_seen", n);
        chk("latency", n, D);
        chk("busy_at_done", busy, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; cin = 1'b0; a = '0; b = '0;
        start1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h5678, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0);
        run_op(16'h9999, 16'h9999, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b1);
        run_op(16'h00A3, 16'h0001, 1'b0);
        run_op(16'h0042, 16'h0017, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1);

        // start held high across a whole operation with operands churning during RUN
        wait_idle();
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        sb.push_back(model(16'h1111, 16'h2222, 1'b0));
        @(posedge clk); #1;
        a = 16'h9999; b = 16'h9999; cin = 1'b1;
        repeat (D) begin
            @(posedge clk); #1;
            a = a - 16'h1111;
        end
        chk("held_done", done, 1'b1);
        @(posedge clk); #1;
        chk("held_k5_busy", busy, 1'b0);
        chk("held_k5_done", done, 1'b0);
        a = 16'h4321; b = 16'h1234; cin = 1'b1;
        sb.push_back(model(16'h4321, 16'h1234, 1'b1));
        @(posedge clk); #1;
        chk("held_k6_busy", busy, 1'b1);
        a = 16'h8888; b = 16'h7777; cin = 1'b0;
        start = 1'b0;
        wait_done("held_second_done", n);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("single_accept", busy, 1'b0);

        // abort in the second RUN cycle
        wait_idle();
        a = 16'h0AB5; b = 16'h0123; cin = 1'b0; start = 1'b1;
        sb.push_back(model(16'h0AB5, 16'h0123, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("pre_abort_err", err, 1'b1);
        chk("pre_abort_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_sum", sum, 16'h0000);
        chk("abort_cout", cout, 1'b0);
        chk("abort_err", err, 1'b0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (D + 2) @(posedge clk);
        #1;
        chk("abort_no_done", done, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b0);

        // DIGITS=1: one RUN edge then DONE
        a1 = 4'd7; b1 = 4'd5; cin1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("d1_busy", busy1, 1'b1);
        @(posedge clk); #1;
        chk("d1_done", done1, 1'b1);
        chk("d1_sum", sum1, 4'd3);
        chk("d1_cout", cout1, 1'b1);
        chk("d1_err", err1, 1'b0);
        @(posedge clk); #1;
        chk("d1_done_clear", done1, 1'b0);
        a1 = 4'hF; b1 = 4'h2; cin1 = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        chk("d1b_done", done1, 1'b1);
        chk("d1b_sum", sum1, 4'd7);
        chk("d1b_cout", cout1, 1'b1);
        chk("d1b_err", err1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
